dot8_mac: RTL and testbench

Eight-lane unsigned byte dot-product accumulator. It sits directly downstream of the afu MMIO write decoder. The host loads two 64-bit operand words (A and B, each eight packed bytes), then pulses start. The block computes the sum of A[i]*B[i] for i=0..7 through a two-stage multiply/accumulate pipeline and adds it into a 24-bit accumulator. The afu MMIO read mux returns `result` zero-extended to 64 bits.

---
 rtl/dot8_mac.sv | 90 +++++++++
 tb/tb_dot8_mac.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dot8_mac.sv
// Eight-lane unsigned byte dot-product accumulated into a wrapping 24-bit register.
// Start-to-done is 10 cycles; strobes arriving while busy are dropped, so the host must wait for done.
module dot8_mac (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_wr,
  input  logic        b_wr,
  input  logic [63:0] wr_data,
  input  logic        start,
  input  logic        clr,
  output logic        busy,
  output logic        done,
  output logic [23:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, b_q;
  logic [2:0]  idx_q;
  logic [15:0] prod_q;
  logic        prod_vld_q;
  logic [23:0] acc_q;

  logic [7:0]  a_lane, b_lane;
  logic [15:0] prod_d;
  logic        idle;

  assign idle   = (state_q == IDLE);
  assign a_lane = a_q[{idx_q, 3'b000} +: 8];
  assign b_lane = b_q[{idx_q, 3'b000} +: 8];
  assign prod_d = {8'b0, a_lane} * {8'b0, b_lane};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (idx_q == 3'd7) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      MUL, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Stage 1 issues one lane per MUL cycle; stage 2 folds it in one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (idle && a_wr) a_q <= wr_data;
      if (idle && b_wr) b_q <= wr_data;

      if (idle && start)         idx_q <= 3'd0;
      else if (state_q == MUL)   idx_q <= idx_q + 3'd1;

      if (state_q == MUL) prod_q <= prod_d;
      prod_vld_q <= (state_q == MUL);

      // clr only acts in IDLE, where no product is pending, so it never races an add.
      if (idle && clr)     acc_q <= '0;
      else if (prod_vld_q) acc_q <= acc_q + {8'b0, prod_q};
    end
  end

  assign result = acc_q;

endmodule

// File: tb/tb_dot8_mac.sv
// Randomized plus directed bench for dot8_mac against a plain-arithmetic accumulator model.
module tb_dot8_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_wr = 1'b0;
  logic        b_wr = 1'b0;
  logic [63:0] wr_data = '0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        busy;
  logic        done;
  logic [23:0] result;

  dot8_mac dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_wr    (a_wr),
    .b_wr    (b_wr),
    .wr_data (wr_data),
    .start   (start),
    .clr     (clr),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned acc_m = 0;
  logic [63:0] a_m = '0;
  logic [63:0] b_m = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned dot(input logic [63:0] a, input logic [63:0] b);
    int unsigned s = 0;
    for (int i = 0; i < 8; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
    return s;
  endfunction

  // All tasks begin and end right after a falling edge.
  task automatic load(input logic wa, input logic wb, input logic [63:0] v);
    a_wr = wa; b_wr = wb; wr_data = v;
    if (wa) a_m = v;
    if (wb) b_m = v;
    @(negedge clk);
    a_wr = 1'b0; b_wr = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    acc_m = 0;
    chk("clr_result", {40'b0, result}, 64'(acc_m));
  endtask

  task automatic run(input logic with_clr, input logic inject, input string tag);
    int busy_n = 0;
    int done_n = 0;
    int done_k = -1;
    start = 1'b1; clr = with_clr;
    if (with_clr) acc_m = 0;
    acc_m = (acc_m + dot(a_m, b_m)) % (1 << 24);
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (inject && k == 2) begin
        a_wr = 1'b1; wr_data = '0; start = 1'b1; clr = 1'b1;
      end
      if (k == 3) begin
        a_wr = 1'b0; start = 1'b0; clr = 1'b0;
      end
    end
    chk({tag, "_done_lat"}, 64'(done_k), 64'd9);
    chk({tag, "_done_cnt"}, 64'(done_n), 64'd1);
    chk({tag, "_busy_cnt"}, 64'(busy_n), 64'd9);
    chk({tag, "_result"}, {40'b0, result}, 64'(acc_m));
  endtask

  initial begin
    #12;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_result", {40'b0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load(1'b1, 1'b0, 64'h0807060504030201);
    load(1'b0, 1'b1, 64'h0101010101010101);
    run(1'b0, 1'b0, "basic");
    chk("basic_const", {40'b0, result}, 64'h24);
    run(1'b0, 1'b0, "accum");
    chk("accum_const", {40'b0, result}, 64'h48);
    do_clr();

    load(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF);
    run(1'b1, 1'b0, "max1");
    chk("max1_const", {40'b0, result}, 64'h07F008);
    for (int r = 0; r < 32; r++) run(1'b0, 1'b0, "maxn");
    chk("max33_wrap", {40'b0, result}, 64'h05F108);

    load(1'b1, 1'b1, 64'h0101010101010101);
    run(1'b1, 1'b1, "ignore");
    chk("ignore_const", {40'b0, result}, 64'h08);
    run(1'b0, 1'b0, "ignore_next");
    chk("ignore_next_const", {40'b0, result}, 64'h10);

    load(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    chk("midrst_result", {40'b0, result}, 64'd0);
    acc_m = 0; a_m = '0; b_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(1'b1, 1'b1, 64'h0101010101010101);
    run(1'b0, 1'b0, "after_rst");
    chk("after_rst_const", {40'b0, result}, 64'h08);

    load(1'b1, 1'b1, 64'h0202020202020202);
    do_clr();
    run(1'b0, 1'b0, "simul");
    chk("simul_const", {40'b0, result}, 64'h20);

    for (int r = 0; r < 24; r++) begin
      logic [63:0] va, vb;
      va = {$urandom, $urandom};
      vb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        load(1'b1, 1'b1, va);
      end else begin
        load(1'b1, 1'b0, va);
        load(1'b0, 1'b1, vb);
      end
      if ($urandom_range(0, 5) == 0) do_clr();
      run(1'(($urandom_range(0, 3) == 0)), 1'(($urandom_range(0, 2) == 0)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
